// File: rtl/uart_rx_if.sv
// Serial receive port bundle: line and frame configuration in, received character and status out.
interface uart_rx_if;
  logic        rx;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic [18:0] k;
  logic        clr;
  logic [7:0]  data;
  logic        rxrdy;
  logic        ferr;
  logic        perr;
  logic        ovf;
  logic        busy;

  modport master (
    output rx, eight, pen, ohel, k, clr,
    input  data, rxrdy, ferr, perr, ovf, busy
  );

  modport slave (
    input  rx, eight, pen, ohel, k, clr,
    output data, rxrdy, ferr, perr, ovf, busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: mid-bit sampling of 7/8 data bits with optional parity, status flags and overrun.
module uart_rx_core (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_nxt;
  logic        rx_p0, rxs, rxs_d;
  logic [18:0] cnt, k_l;
  logic        eight_l, pen_l, ohel_l;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        perr_f;
  logic        start_det, half_hit, full_hit, last_bit;
  logic        busy, load_cfg, cnt_clr, shift_en, par_en, done;
  logic [7:0]  data_r;
  logic        rxrdy_r, ferr_r, perr_r, ovf_r;

  function automatic logic [18:0] clamp_k(input logic [18:0] kin);
    return (kin < 19'd4) ? 19'd4 : kin;
  endfunction

  assign start_det = rxs_d & ~rxs;
  assign half_hit  = (cnt == ({1'b0, k_l[18:1]} - 19'd1));
  assign full_hit  = (cnt == (k_l - 19'd1));
  assign last_bit  = (bit_idx == (eight_l ? 3'd7 : 3'd6));

  // Line synchronizer; rxs_d holds the previous synchronized value for edge detect
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rxs   <= rx_p0;
      rxs_d <= rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_det) state_nxt = START;
      START:   if (half_hit)  state_nxt = rxs ? IDLE : DATA;
      DATA:    if (full_hit && last_bit) state_nxt = pen_l ? PARITY : STOP;
      PARITY:  if (full_hit)  state_nxt = STOP;
      STOP:    if (full_hit)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b1;
    load_cfg = 1'b0;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        load_cfg = start_det;
        cnt_clr  = 1'b1;
      end
      START:  cnt_clr = half_hit;
      DATA: begin
        shift_en = full_hit;
        cnt_clr  = full_hit;
      end
      PARITY: begin
        par_en  = full_hit;
        cnt_clr = full_hit;
      end
      STOP: begin
        done    = full_hit;
        cnt_clr = full_hit;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt + 19'd1;
  end

  // Frame configuration is frozen at start detect so mid-frame input changes are ignored
  always_ff @(posedge clk) begin
    if (load_cfg) begin
      k_l     <= clamp_k(bus.k);
      eight_l <= bus.eight;
      pen_l   <= bus.pen;
      ohel_l  <= bus.ohel;
      shreg   <= '0;
      bit_idx <= '0;
      perr_f  <= 1'b0;
    end
    if (shift_en) begin
      shreg[bit_idx] <= rxs;
      bit_idx        <= bit_idx + 3'd1;
    end
    if (par_en) perr_f <= (((^shreg) ^ rxs) != ohel_l);
  end

  // Completion outranks clr; ovf compares against rxrdy as it stood before this edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_r  <= '0;
      rxrdy_r <= 1'b0;
      ferr_r  <= 1'b0;
      perr_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (done) begin
      data_r  <= shreg;
      rxrdy_r <= 1'b1;
      perr_r  <= perr_f;
      ferr_r  <= ~rxs;
      ovf_r   <= ovf_r | rxrdy_r;
    end else if (bus.clr) begin
      rxrdy_r <= 1'b0;
      ferr_r  <= 1'b0;
      perr_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end
  end

  assign bus.data  = data_r;
  assign bus.rxrdy = rxrdy_r;
  assign bus.ferr  = ferr_r;
  assign bus.perr  = perr_r;
  assign bus.ovf   = ovf_r;
  assign bus.busy  = busy;
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames are queued with their expected result, a monitor checks completions.
module tb_uart_rx_core;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  uart_rx_if bus();

  uart_rx_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  exp_t       exp_q[$];
  bit         m_rxrdy;
  bit         m_ovf;
  logic [7:0] m_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a completed frame shows as busy falling while rxrdy is high
  initial begin
    logic busy_prev;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_prev && !bus.busy && bus.rxrdy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got data %0h with no frame outstanding", bus.data);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", bus.data, e.data);
          check("frame_perr", bus.perr, e.perr);
          check("frame_ferr", bus.ferr, e.ferr);
          check("frame_ovf",  bus.ovf,  e.ovf);
        end
      end
      busy_prev = bus.busy;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, %0d frames outstanding", exp_q.size());
    $fatal(1, "bench time limit");
  end

  task automatic send_frame(input logic [7:0] b, input logic e8, input logic p, input logic odd,
                            input int kin, input logic par_flip, input logic stop_bit,
                            input bit clr_done, input bit chg_mid);
    int         ke, n, dly;
    logic [7:0] d;
    logic       pbit;
    logic       bits[$];
    exp_t       e;
    ke   = (kin < 4) ? 4 : kin;
    n    = e8 ? 8 : 7;
    d    = e8 ? b : {1'b0, b[6:0]};
    pbit = (^d) ^ odd ^ par_flip;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) bits.push_back(d[i]);
    if (p) bits.push_back(pbit);
    bits.push_back(stop_bit);
    e.data = d;
    e.perr = p && (((^d) ^ pbit) != odd);
    e.ferr = !stop_bit;
    e.ovf  = m_ovf | m_rxrdy;
    m_ovf   = e.ovf;
    m_rxrdy = 1'b1;
    m_data  = d;
    exp_q.push_back(e);
    bus.eight = e8;
    bus.pen   = p;
    bus.ohel  = odd;
    bus.k     = kin[18:0];
    dly = 3 + ke / 2 + ke * (1 + n + (p ? 1 : 0));
    fork
      begin
        foreach (bits[i]) begin
          bus.rx = bits[i];
          repeat (ke) @(posedge clk);
          #1;
        end
        bus.rx = 1'b1;
        repeat (ke + 4) @(posedge clk);
        #1;
      end
      begin
        if (clr_done) begin
          repeat (dly - 1) @(posedge clk);
          #1 bus.clr = 1'b1;
          @(posedge clk);
          #1 bus.clr = 1'b0;
          check("clr_vs_done_rxrdy", bus.rxrdy, 1);
        end
      end
      begin
        if (chg_mid) begin
          repeat (ke * 3) @(posedge clk);
          #1;
          bus.k     = 19'd5;
          bus.eight = ~e8;
          bus.pen   = ~p;
          bus.ohel  = ~odd;
        end
      end
    join
  endtask

  task automatic clr_pulse();
    bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
    m_rxrdy = 1'b0;
    m_ovf   = 1'b0;
    check("clr_rxrdy", bus.rxrdy, 0);
    check("clr_ferr",  bus.ferr,  0);
    check("clr_perr",  bus.perr,  0);
    check("clr_ovf",   bus.ovf,   0);
    check("clr_data_kept", bus.data, m_data);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_rxrdy = 1'b0;
    m_ovf   = 1'b0;
    m_data  = 8'h00;
    reset     = 1'b0;
    bus.rx    = 1'b1;
    bus.clr   = 1'b0;
    bus.eight = 1'b1;
    bus.pen   = 1'b0;
    bus.ohel  = 1'b0;
    bus.k     = 19'd16;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  bus.data,  0);
    check("rst_rxrdy", bus.rxrdy, 0);
    check("rst_ferr",  bus.ferr,  0);
    check("rst_perr",  bus.perr,  0);
    check("rst_ovf",   bus.ovf,   0);
    check("rst_busy",  bus.busy,  0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    send_frame(8'hA5, 1, 0, 0, 16, 0, 1, 0, 0);
    clr_pulse();
    send_frame(8'h41, 0, 1, 0, 16, 0, 1, 0, 0);
    clr_pulse();
    send_frame(8'h41, 0, 1, 0, 16, 1, 1, 0, 0);
    clr_pulse();
    send_frame(8'h3C, 1, 0, 0, 16, 0, 0, 0, 0);
    clr_pulse();
    send_frame(8'h55, 1, 0, 0, 16, 0, 1, 0, 0);
    send_frame(8'h55, 1, 0, 0, 16, 0, 1, 0, 0);
    clr_pulse();

    // False start: short low pulse, bus goes busy then returns idle with flags untouched
    bus.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("fs_busy_high", bus.busy, 1);
    repeat (20) @(posedge clk);
    #1;
    check("fs_busy_low", bus.busy,  0);
    check("fs_rxrdy",    bus.rxrdy, 0);
    check("fs_ferr",     bus.ferr,  0);
    check("fs_perr",     bus.perr,  0);
    check("fs_ovf",      bus.ovf,   0);
    check("fs_data",     bus.data,  m_data);

    // Reset in the middle of a data bit
    send_frame(8'h99, 1, 0, 0, 16, 0, 1, 0, 0);
    bus.rx = 1'b0;
    repeat (16) @(posedge clk);
    #1 bus.rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy", bus.busy, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_data",  bus.data,  0);
    check("mid_rst_rxrdy", bus.rxrdy, 0);
    check("mid_rst_ferr",  bus.ferr,  0);
    check("mid_rst_perr",  bus.perr,  0);
    check("mid_rst_ovf",   bus.ovf,   0);
    check("mid_rst_busy",  bus.busy,  0);
    reset   = 1'b1;
    m_rxrdy = 1'b0;
    m_ovf   = 1'b0;
    m_data  = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    send_frame(8'h0F, 1, 0, 0, 16, 0, 1, 0, 0);

    // rxrdy still set from 8'h0F: clr on the completion edge loses, and ovf is raised
    send_frame(8'hA7, 1, 0, 0, 16, 0, 1, 1, 0);
    clr_pulse();
    send_frame(8'hC3, 1, 0, 0, 16, 0, 1, 0, 1);
    clr_pulse();
    send_frame(8'h6B, 1, 1, 1, 2, 0, 1, 0, 0);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      logic       e8, p, odd, flip, stp;
      int         kin;
      b    = 8'($urandom);
      e8   = 1'($urandom);
      p    = 1'($urandom);
      odd  = 1'($urandom);
      flip = p && ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 4) != 0);
      kin  = int'($urandom_range(1, 20));
      send_frame(b, e8, p, odd, kin, flip, stp, 0, 0);
      if ($urandom_range(0, 2) == 0) clr_pulse();
    end

    repeat (50) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- rx  in  1  asynchronous serial line, idle high
- eight  in  1  1 = 8 data bits, 0 = 7 data bits
- pen  in  1  1 = parity bit present
- ohel  in  1  parity sense: 1 = odd, 0 = even
- k  in  19  bit period in clk cycles
- clr  in  1  one-cycle pulse that clears the status flags
- data  out  8  last received character
- rxrdy  out  1  character available
- ferr  out  1  framing error
- perr  out  1  parity error
- ovf  out  1  overrun
- busy  out  1  frame in progress

Function
REQ-002 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-003 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-004 SHALL latch eight, pen, ohel and k on start detect; changes to these inputs mid-frame SHALL have no effect.
REQ-005 SHALL clamp latched k values below 4 to 4.
REQ-006 IDLE: a 1->0 transition on rxs SHALL enter START and clear the 19-bit bit counter.
REQ-007 START: at count == (k>>1)-1, sample rxs; rxs=1 is a false start (return to IDLE, no flags change); rxs=0 enters DATA with the counter cleared.
REQ-008 DATA/PARITY/STOP: sample rxs each time the counter reaches k-1, then clear the counter; sample points sit at mid-bit.
REQ-009 Data bits SHALL arrive LSB first; 8 bits when eight=1, 7 bits when eight=0 with data[7] forced to 0.
REQ-010 After the last data bit, enter PARITY if pen=1, else STOP.
REQ-011 Parity check: XOR of received data bits and parity bit SHALL equal ohel; a mismatch sets the frame parity error.
REQ-012 STOP: a sampled rxs=0 sets the frame framing error; in either case return to IDLE in the next cycle.
REQ-013 On the STOP sample edge, the following SHALL update together:
- data loaded
- rxrdy <= 1
- perr <= frame parity error
- ferr <= frame framing error
- ovf <= 1 if rxrdy was already 1
REQ-014 On overrun, data SHALL be overwritten with the new character.
REQ-015 perr and ferr SHALL reflect only the most recent frame; ovf SHALL be sticky until clr.
REQ-016 clr=1 SHALL clear rxrdy, ferr, perr and ovf on the next edge; data SHALL be unchanged.
REQ-017 If clr coincides with frame completion, completion SHALL win; ovf evaluates against rxrdy before that edge.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 In IDLE, line held low after a false start SHALL NOT retrigger until rxs returns high and falls again.
REQ-020 Latency: rxrdy rises 1 cycle after the stop-bit mid-sample, i.e. about (k>>1)+k*(1+n+p)+1 cycles after the falling edge at the synchronizer output, where n is the data-bit count and p = pen.

Reset
REQ-021 SHALL, with reset=0 at a clk edge, force:
- state IDLE, counter 0
- data=8'h00; rxrdy=ferr=perr=ovf=busy=0
- synchronizer flops = 1
REQ-022 Reset asserted mid-frame SHALL abort the frame with no flag or data update; reset has priority over clr and completion.

Verification
REQ-023 Bench SHALL cover:
- k=16, 8N1 (eight=1, pen=0), send 8'hA5 -> data=8'hA5, rxrdy=1, ferr=perr=ovf=0.
- k=16, 7E1 (eight=0, pen=1, ohel=0), send 7'h41 with parity 0 -> data=8'h41, perr=0; repeat with parity 1 -> perr=1.
- k=16, 8N1, send 8'h3C with stop bit driven 0 -> data=8'h3C, ferr=1, rxrdy=1.
- Two 8'h55 frames with no clr between -> ovf=1, data=8'h55; then clr pulse -> rxrdy=ferr=perr=ovf=0 on next edge.
- rx low 4 cycles (k=16) then high -> false start; busy returns 0 and no flag changes. Also: reset=0 mid-data-bit -> all outputs 0, and a following clean frame 8'h0F is received correctly.
- clr coincident with completion edge -> rxrdy=1 after that edge; changing k and eight mid-frame does not corrupt an 8'hC3 frame.
